// File: rtl/br_flag_unit_pkg.sv
// br_flag_unit_pkg: condition codes, squash states and flag bit positions shared by the branch/flag unit
package br_flag_unit_pkg;
    localparam logic [2:0] COND_NEQ = 3'b000;
    localparam logic [2:0] COND_EQ  = 3'b001;
    localparam logic [2:0] COND_GT  = 3'b010;
    localparam logic [2:0] COND_LT  = 3'b011;
    localparam logic [2:0] COND_GTE = 3'b100;
    localparam logic [2:0] COND_LTE = 3'b101;
    localparam logic [2:0] COND_OV  = 3'b110;
    localparam logic [2:0] COND_UNC = 3'b111;
    typedef enum logic {SQ_IDLE = 1'b0, SQ_SQUASH = 1'b1} sq_state_t;
    localparam int FLG_ZR  = 2;
    localparam int FLG_OV  = 1;
    localparam int FLG_NEG = 0;
endpackage

// File: rtl/br_flag_unit_cond.sv
// br_cond_eval: decodes a branch condition code against the registered Z/V/N flags
module br_cond_eval
    import br_flag_unit_pkg::*;
(
    input  logic [2:0] cond,
    input  logic       z,
    input  logic       v,
    input  logic       n,
    output logic       cond_true
);
    always_comb begin
        cond_true = 1'b1;
        case (cond)
            COND_NEQ: cond_true = ~z;
            COND_EQ:  cond_true = z;
            COND_GT:  cond_true = ~z & ~n;
            COND_LT:  cond_true = n;
            COND_GTE: cond_true = z | ~n;
            COND_LTE: cond_true = n | z;
            COND_OV:  cond_true = v;
            COND_UNC: cond_true = 1'b1;
            default:  cond_true = 1'b1;
        endcase
    end
endmodule

// File: rtl/br_flag_unit.sv
// br_flag_unit: EX-stage flag register, branch resolution, wrong-path squash and branch counters
module br_flag_unit
    import br_flag_unit_pkg::*;
#(
    parameter int FLUSH_CYC = 2,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall_EX,
    input  logic [2:0]       flg_en,
    input  logic             zr,
    input  logic             ov,
    input  logic             neg,
    input  logic [15:0]      alu_dst,
    input  logic             br_instr_EX,
    input  logic             jmp_instr_EX,
    input  logic [2:0]       br_cond_EX,
    input  logic             clr_cnt,
    output logic             flow_change,
    output logic [15:0]      target_pc,
    output logic             flush_IF_ID,
    output logic             flush_ID_EX,
    output logic             squash_EX,
    output logic             zr_q,
    output logic             ov_q,
    output logic             neg_q,
    output logic [CNT_W-1:0] br_cnt,
    output logic [CNT_W-1:0] taken_cnt
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    sq_state_t  state, state_nxt;
    logic [2:0] sq_cnt, sq_cnt_nxt;
    logic       valid, cond_true, br_eval;
    br_cond_eval u_cond (
        .cond      (br_cond_EX),
        .z         (zr_q),
        .v         (ov_q),
        .n         (neg_q),
        .cond_true (cond_true)
    );
    assign squash_EX   = state == SQ_SQUASH;
    assign valid       = ~stall_EX & ~squash_EX;
    assign br_eval     = valid & (br_instr_EX | jmp_instr_EX);
    assign flow_change = valid & (jmp_instr_EX | (br_instr_EX & cond_true));
    assign target_pc   = flow_change ? alu_dst : 16'h0000;
    assign flush_IF_ID = flow_change;
    assign flush_ID_EX = flow_change;
    always_comb begin
        state_nxt  = state;
        sq_cnt_nxt = sq_cnt;
        if (state == SQ_IDLE) begin
            state_nxt  = flow_change ? SQ_SQUASH : SQ_IDLE;
            sq_cnt_nxt = flow_change ? 3'(FLUSH_CYC) : sq_cnt;
        end else if (!stall_EX) begin
            state_nxt  = (sq_cnt == 3'd1) ? SQ_IDLE : SQ_SQUASH;
            sq_cnt_nxt = sq_cnt - 3'd1;
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= SQ_IDLE;
            sq_cnt <= 3'd0;
        end else begin
            state  <= state_nxt;
            sq_cnt <= sq_cnt_nxt;
        end
    end
    // a branch's own flg_en is ignored so it can never clobber the flags it tested
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            zr_q  <= 1'b0;
            ov_q  <= 1'b0;
            neg_q <= 1'b0;
        end else if (valid && !br_instr_EX) begin
            if (flg_en[FLG_ZR])  zr_q  <= zr;
            if (flg_en[FLG_OV])  ov_q  <= ov;
            if (flg_en[FLG_NEG]) neg_q <= neg;
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            br_cnt    <= '0;
            taken_cnt <= '0;
        end else if (clr_cnt) begin
            br_cnt    <= '0;
            taken_cnt <= '0;
        end else begin
            if (br_eval && br_cnt != CNT_MAX) br_cnt <= br_cnt + CNT_W'(1);
            if (flow_change && taken_cnt != CNT_MAX) taken_cnt <= taken_cnt + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_br_flag_unit.sv
// tb_br_flag_unit: directed self-checking bench for br_flag_unit (CNT_W=4, FLUSH_CYC=2)
module tb_br_flag_unit;
    localparam int CNT_W = 4;
    logic             clk = 1'b0;
    logic             rst_n;
    logic             stall_EX;
    logic [2:0]       flg_en;
    logic             zr, ov, neg;
    logic [15:0]      alu_dst;
    logic             br_instr_EX, jmp_instr_EX;
    logic [2:0]       br_cond_EX;
    logic             clr_cnt;
    logic             flow_change;
    logic [15:0]      target_pc;
    logic             flush_IF_ID, flush_ID_EX, squash_EX;
    logic             zr_q, ov_q, neg_q;
    logic [CNT_W-1:0] br_cnt, taken_cnt;
    int checks = 0;
    int errors = 0;

    br_flag_unit #(.FLUSH_CYC(2), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .stall_EX     (stall_EX),
        .flg_en       (flg_en),
        .zr           (zr),
        .ov           (ov),
        .neg          (neg),
        .alu_dst      (alu_dst),
        .br_instr_EX  (br_instr_EX),
        .jmp_instr_EX (jmp_instr_EX),
        .br_cond_EX   (br_cond_EX),
        .clr_cnt      (clr_cnt),
        .flow_change  (flow_change),
        .target_pc    (target_pc),
        .flush_IF_ID  (flush_IF_ID),
        .flush_ID_EX  (flush_ID_EX),
        .squash_EX    (squash_EX),
        .zr_q         (zr_q),
        .ov_q         (ov_q),
        .neg_q        (neg_q),
        .br_cnt       (br_cnt),
        .taken_cnt    (taken_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic cond_ref(input logic [2:0] c, input logic z, input logic v, input logic n);
        case (c)
            3'd0: return !z;
            3'd1: return z;
            3'd2: return !z && !n;
            3'd3: return n;
            3'd4: return z || !n;
            3'd5: return n || z;
            3'd6: return v;
            default: return 1'b1;
        endcase
    endfunction

    initial begin
        rst_n = 1'b0; stall_EX = 1'b0; flg_en = 3'b000; zr = 1'b0; ov = 1'b0; neg = 1'b0;
        alu_dst = 16'h0000; br_instr_EX = 1'b0; jmp_instr_EX = 1'b0; br_cond_EX = 3'b000; clr_cnt = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        chk("rst_br_cnt", 32'(br_cnt), 0);
        chk("rst_taken_cnt", 32'(taken_cnt), 0);
        chk("rst_squash", 32'(squash_EX), 0);
        chk("rst_flags", {29'd0, zr_q, ov_q, neg_q}, 0);

        // flag setter then BEQ
        zr = 1'b1; flg_en = 3'b111;
        tick();
        chk("flag_zr_set", 32'(zr_q), 1);
        zr = 1'b0; br_instr_EX = 1'b1; br_cond_EX = 3'b001; alu_dst = 16'h0040;
        #1;
        chk("beq_flow", 32'(flow_change), 1);
        chk("beq_target", 32'(target_pc), 32'h40);
        chk("beq_flush", {30'd0, flush_IF_ID, flush_ID_EX}, 3);
        tick();
        chk("beq_squash1", 32'(squash_EX), 1);
        chk("beq_no_flag_upd", 32'(zr_q), 1);
        chk("beq_br_cnt", 32'(br_cnt), 1);
        chk("beq_taken_cnt", 32'(taken_cnt), 1);

        // squashed flag setter, then squashed branches
        br_instr_EX = 1'b0; zr = 1'b0; neg = 1'b1; flg_en = 3'b111;
        #1;
        chk("sq_target_zero", 32'(target_pc), 0);
        tick();
        chk("sq_zr_hold", 32'(zr_q), 1);
        chk("sq_neg_hold", 32'(neg_q), 0);
        chk("beq_squash2", 32'(squash_EX), 1);
        flg_en = 3'b000; neg = 1'b0; br_instr_EX = 1'b1; br_cond_EX = 3'b000;
        #1;
        chk("sq_bne_flow", 32'(flow_change), 0);
        br_cond_EX = 3'b111;
        #1;
        chk("sq_unc_flow", 32'(flow_change), 0);
        tick();
        chk("sq_end", 32'(squash_EX), 0);
        chk("sq_br_cnt", 32'(br_cnt), 1);

        // stalled taken branch
        stall_EX = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("stall_flow", 32'(flow_change), 0);
            tick();
            chk("stall_br_cnt", 32'(br_cnt), 1);
        end
        stall_EX = 1'b0;
        #1;
        chk("unstall_flow", 32'(flow_change), 1);
        tick();
        chk("unstall_br_cnt", 32'(br_cnt), 2);
        chk("unstall_taken", 32'(taken_cnt), 2);
        br_instr_EX = 1'b0; stall_EX = 1'b1;
        tick();
        tick();
        chk("stall_sq_hold", 32'(squash_EX), 1);
        stall_EX = 1'b0;
        tick();
        chk("stall_sq_ext", 32'(squash_EX), 1);
        tick();
        chk("stall_sq_end", 32'(squash_EX), 0);

        // condition sweep: 8 flag combos x 8 codes, evaluated combinationally without clocking
        for (int f = 0; f < 8; f++) begin
            logic [2:0] fv;
            fv = 3'(f);
            br_instr_EX = 1'b0; flg_en = 3'b111; zr = fv[2]; ov = fv[1]; neg = fv[0];
            tick();
            chk("sweep_flags", {29'd0, zr_q, ov_q, neg_q}, 32'(fv));
            flg_en = 3'b000; br_instr_EX = 1'b1;
            for (int c = 0; c < 8; c++) begin
                br_cond_EX = 3'(c);
                #1;
                chk($sformatf("cond%0d_f%0d", c, f), 32'(flow_change), 32'(cond_ref(3'(c), fv[2], fv[1], fv[0])));
            end
            br_instr_EX = 1'b0;
        end
        chk("sweep_br_cnt", 32'(br_cnt), 2);

        // saturation with 20 jumps
        clr_cnt = 1'b1;
        tick();
        clr_cnt = 1'b0;
        chk("clr_br_cnt", 32'(br_cnt), 0);
        for (int i = 0; i < 20; i++) begin
            jmp_instr_EX = 1'b1; alu_dst = 16'(16'h1000 + i);
            #1;
            chk("jmp_flow", 32'(flow_change), 1);
            chk("jmp_target", 32'(target_pc), 32'(16'h1000 + i));
            tick();
            jmp_instr_EX = 1'b0;
            tick();
            tick();
        end
        chk("sat_br_cnt", 32'(br_cnt), 32'hF);
        chk("sat_taken_cnt", 32'(taken_cnt), 32'hF);
        jmp_instr_EX = 1'b1; clr_cnt = 1'b1;
        tick();
        jmp_instr_EX = 1'b0; clr_cnt = 1'b0;
        chk("clr_prio_br", 32'(br_cnt), 0);
        chk("clr_prio_taken", 32'(taken_cnt), 0);
        tick();
        tick();

        // async reset mid-squash
        jmp_instr_EX = 1'b1;
        tick();
        jmp_instr_EX = 1'b0;
        chk("pre_rst_squash", 32'(squash_EX), 1);
        chk("pre_rst_cnt", 32'(br_cnt), 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_squash", 32'(squash_EX), 0);
        chk("mid_rst_flags", {29'd0, zr_q, ov_q, neg_q}, 0);
        chk("mid_rst_cnts", {24'd0, br_cnt, taken_cnt}, 0);
        chk("mid_rst_flow", {15'd0, flow_change, target_pc}, 0);
        #2;
        rst_n = 1'b1;
        tick();
        chk("post_rst_squash", 32'(squash_EX), 0);
        chk("post_rst_cnts", {24'd0, br_cnt, taken_cnt}, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
